// File: rtl/vlc_bit_packer_if.sv
// Code-in / word-out bus of the VLC bit packer.
// The master modport belongs to the code producer, the slave modport to the packer.
interface vlc_bit_packer_if #(
    parameter int CODE_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
);
    logic                  in_valid;
    logic [CODE_WIDTH-1:0] in_code;
    logic [LEN_WIDTH-1:0]  in_len;
    logic                  flush;
    logic                  out_valid;
    logic [31:0]           out_word;
    logic                  out_last;
    logic [2:0]            out_nbytes;
    logic [31:0]           total_bits;
    logic                  done;
    logic                  err;

    modport master (
        output in_valid, in_code, in_len, flush,
        input  out_valid, out_word, out_last, out_nbytes, total_bits, done, err
    );

    modport slave (
        input  in_valid, in_code, in_len, flush,
        output out_valid, out_word, out_last, out_nbytes, total_bits, done, err
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs MSB-first variable-length codes into 32-bit big-endian words.
// A flush closes the stream: the zero-padded residue is emitted as the last word
// with its byte count, then the packer parks in DONE until the next sync clear.
module vlc_bit_packer #(
    parameter int CODE_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sync_reset_n,
    vlc_bit_packer_if.slave     bus
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    // Valid bits sit left-aligned at bit 63; everything below them is kept zero.
    logic [63:0] acc_reg, acc_next;
    logic [5:0]  fill_reg, fill_next;
    logic [31:0] total_reg, total_next;
    logic        err_reg, err_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_word_reg, out_word_next;
    logic        out_last_reg, out_last_next;
    logic [2:0]  out_nbytes_reg, out_nbytes_next;
    logic        done_reg, done_next;

    // Length clamping and placement of the incoming code directly below the fill.
    logic                  over_len;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [CODE_WIDTH-1:0] code_mask;
    logic [63:0]           code_ext;
    logic [6:0]            sum;
    logic [6:0]            shift;
    logic [63:0]           appended;

    assign over_len  = bus.in_len > LEN_WIDTH'(CODE_WIDTH);
    assign eff_len   = over_len ? LEN_WIDTH'(CODE_WIDTH) : bus.in_len;
    assign code_mask = (eff_len == LEN_WIDTH'(CODE_WIDTH)) ? '1
                     : ((CODE_WIDTH'(1) << eff_len) - CODE_WIDTH'(1));
    assign code_ext  = {{(64-CODE_WIDTH){1'b0}}, bus.in_code & code_mask};
    assign sum       = {1'b0, fill_reg} + 7'(eff_len);
    // fill <= 31 and len <= 32 keep sum <= 63, so the shift is always at least 1.
    assign shift     = 7'd64 - sum;
    assign appended  = acc_reg | (code_ext << shift);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= RUN;
        else          state_reg <= state_next;
    end

    // Next-state, accumulator update and output word selection.
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        fill_next       = fill_reg;
        total_next      = total_reg;
        err_next        = err_reg;
        out_valid_next  = 1'b0;
        out_word_next   = out_word_reg;
        out_last_next   = 1'b0;
        out_nbytes_next = out_nbytes_reg;
        done_next       = 1'b0;

        case (state_reg)
            RUN: begin
                if (bus.in_valid) begin
                    total_next = total_reg + 32'(eff_len);
                    if (over_len) err_next = 1'b1;
                    if (sum >= 7'd32) begin
                        out_valid_next  = 1'b1;
                        out_word_next   = appended[63:32];
                        out_nbytes_next = 3'd4;
                        acc_next        = appended << 32;
                        fill_next       = 6'(sum - 7'd32);
                    end else begin
                        acc_next  = appended;
                        fill_next = sum[5:0];
                    end
                end
                // Flush sees the fill after this cycle's code has been appended.
                if (bus.flush) begin
                    if (fill_next != 6'd0) begin
                        state_next = DRAIN;
                    end else begin
                        state_next    = DONE;
                        done_next     = 1'b1;
                        out_last_next = out_valid_next;
                    end
                end
            end
            DRAIN: begin
                out_valid_next  = 1'b1;
                out_last_next   = 1'b1;
                out_word_next   = acc_reg[63:32];
                out_nbytes_next = 3'(({1'b0, fill_reg} + 7'd7) >> 3);
                acc_next        = '0;
                fill_next       = '0;
                done_next       = 1'b1;
                state_next      = DONE;
                if (bus.in_valid) err_next = 1'b1;
            end
            DONE: begin
                if (bus.in_valid || bus.flush) err_next = 1'b1;
            end
            default: state_next = RUN;
        endcase

        // Per-component restart overrides everything, including a pending drain.
        if (!sync_reset_n) begin
            state_next      = RUN;
            acc_next        = '0;
            fill_next       = '0;
            total_next      = '0;
            err_next        = 1'b0;
            out_valid_next  = 1'b0;
            out_word_next   = '0;
            out_last_next   = 1'b0;
            out_nbytes_next = '0;
            done_next       = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg        <= '0;
            fill_reg       <= '0;
            total_reg      <= '0;
            err_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_word_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_nbytes_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            acc_reg        <= acc_next;
            fill_reg       <= fill_next;
            total_reg      <= total_next;
            err_reg        <= err_next;
            out_valid_reg  <= out_valid_next;
            out_word_reg   <= out_word_next;
            out_last_reg   <= out_last_next;
            out_nbytes_reg <= out_nbytes_next;
            done_reg       <= done_next;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_word   = out_word_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.out_nbytes = out_nbytes_reg;
    assign bus.total_bits = total_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_vlc_bit_packer.sv
// Self-checking bench for vlc_bit_packer: directed cases plus random streams,
// compared every cycle against a bit-queue reference model.
module tb_vlc_bit_packer;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    logic clock;
    logic reset_n;
    logic sync_reset_n;

    vlc_bit_packer_if #(.CODE_WIDTH(32), .LEN_WIDTH(6)) bus ();

    vlc_bit_packer #(.CODE_WIDTH(32), .LEN_WIDTH(6)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sync_reset_n (sync_reset_n),
        .bus          (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the pending stream is just a queue of bits.
    bit          q[$];
    int          m_mode;
    logic [31:0] m_total;
    logic        m_err;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_last;
    logic [2:0]  exp_nbytes;
    logic        exp_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_mode     = M_RUN;
        m_total    = '0;
        m_err      = 1'b0;
        exp_valid  = 1'b0;
        exp_word   = '0;
        exp_last   = 1'b0;
        exp_nbytes = '0;
        exp_done   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] c, input logic [5:0] l,
                              input logic f, input logic s);
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_done  = 1'b0;
        if (!s) begin
            model_clear();
        end else if (m_mode == M_RUN) begin
            if (v) begin
                int n;
                n = (l > 6'd32) ? 32 : int'(l);
                if (l > 6'd32) m_err = 1'b1;
                for (int i = n - 1; i >= 0; i--) q.push_back(c[i]);
                m_total = m_total + 32'(n);
                if (q.size() >= 32) begin
                    for (int i = 0; i < 32; i++) exp_word = {exp_word[30:0], q.pop_front()};
                    exp_valid  = 1'b1;
                    exp_nbytes = 3'd4;
                end
            end
            if (f) begin
                if (q.size() > 0) begin
                    m_mode = M_DRAIN;
                end else begin
                    m_mode   = M_DONE;
                    exp_done = 1'b1;
                    exp_last = exp_valid;
                end
            end
        end else if (m_mode == M_DRAIN) begin
            int r;
            r = q.size();
            exp_word = '0;
            for (int i = 0; i < r; i++) exp_word[31-i] = q[i];
            q.delete();
            exp_nbytes = 3'((r + 7) / 8);
            exp_valid  = 1'b1;
            exp_last   = 1'b1;
            exp_done   = 1'b1;
            m_mode     = M_DONE;
            if (v) m_err = 1'b1;
        end else begin
            if (v || f) m_err = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},  32'(bus.out_valid),  32'(exp_valid));
        check({tag, ".word"},   bus.out_word,        exp_word);
        check({tag, ".last"},   32'(bus.out_last),   32'(exp_last));
        check({tag, ".nbytes"}, 32'(bus.out_nbytes), 32'(exp_nbytes));
        check({tag, ".total"},  bus.total_bits,      m_total);
        check({tag, ".done"},   32'(bus.done),       32'(exp_done));
        check({tag, ".err"},    32'(bus.err),        32'(m_err));
        if (exp_valid)
            $display("[TB] %s word=%h last=%0d nbytes=%0d total=%0d",
                     tag, exp_word, exp_last, exp_nbytes, m_total);
    endtask

    // One clock of stimulus; outputs are compared 1 time unit after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] c,
                        input logic [5:0] l, input logic f, input logic s);
        bus.in_valid = v;
        bus.in_code  = c;
        bus.in_len   = l;
        bus.flush    = f;
        sync_reset_n = s;
        @(posedge clock);
        model_edge(v, c, l, f, s);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        model_clear();
        compare_all({tag, ".during"});
        @(posedge clock);
        #1;
        compare_all({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        sync_reset_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_len   = '0;
        bus.flush    = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        compare_all("por");
        reset_n = 1'b1;

        // Two codes completing exactly one word.
        step("clr", 0, 0, 0, 0, 0);
        step("p2a", 1, 32'h5, 3, 0, 1);
        step("p2b", 1, 32'h1FFF_FFFF, 29, 0, 1);
        check("p2_word", bus.out_word, 32'hBFFF_FFFF);
        check("p2_total", bus.total_bits, 32'd32);
        step("p2f", 0, 0, 0, 1, 1);

        // Full word, then a 31-bit residue drained one cycle after flush.
        step("clr", 0, 0, 0, 0, 0);
        step("p3a", 1, 32'h0, 31, 0, 1);
        step("p3b", 1, 32'hFFFF_FFFF, 32, 0, 1);
        check("p3_word0", bus.out_word, 32'h0000_0001);
        step("p3f", 0, 0, 0, 1, 1);
        step("p3d", 0, 0, 0, 0, 1);
        check("p3_drain", bus.out_word, 32'hFFFF_FFFE);
        check("p3_total", bus.total_bits, 32'd63);

        // Code and flush together with a 3-bit residue.
        step("clr", 0, 0, 0, 0, 0);
        step("p4f", 1, 32'h5, 3, 1, 1);
        step("p4d", 0, 0, 0, 0, 1);
        check("p4_drain", bus.out_word, 32'hA000_0000);
        check("p4_nbytes", 32'(bus.out_nbytes), 32'd1);

        // Word on the flush edge plus a 4-bit residue.
        step("clr", 0, 0, 0, 0, 0);
        step("p5a", 1, 32'hABCDE, 20, 0, 1);
        step("p5f", 1, 32'hFFFF, 16, 1, 1);
        check("p5_word", bus.out_word, 32'hABCD_EFFF);
        step("p5d", 0, 0, 0, 0, 1);
        check("p5_drain", bus.out_word, 32'hF000_0000);
        check("p5_total", bus.total_bits, 32'd36);

        // Over-long code, flush with no residue, then traffic while DONE.
        step("clr", 0, 0, 0, 0, 0);
        step("e1", 1, 32'hFFFF_FFFF, 40, 0, 1);
        check("e1_err", 32'(bus.err), 32'd1);
        step("e1f", 0, 0, 0, 1, 1);
        step("e1x", 1, 32'h3, 2, 0, 1);
        step("e1y", 0, 0, 0, 1, 1);

        // Sync clear landing on the drain cycle, then normal packing resumes.
        step("clr", 0, 0, 0, 0, 0);
        step("s1f", 1, 32'h5, 3, 1, 1);
        step("s1r", 1, 32'h7, 3, 0, 0);
        check("s1_total", bus.total_bits, 32'd0);
        step("s1a", 1, 32'h5, 3, 0, 1);
        step("s1b", 1, 32'h1FFF_FFFF, 29, 0, 1);

        // Held sync clear: codes are dropped, nothing comes out.
        for (int i = 0; i < 4; i++) step("hold", 1, $urandom, 6'd32, 1'($urandom), 0);

        // Async reset in the middle of a stream.
        step("a1", 1, 32'hABCDE, 20, 0, 1);
        async_reset("arst");
        step("a2", 1, 32'hFFFF_FFFF, 32, 0, 1);

        // Random streams with occasional flushes, over-long codes and clears.
        for (int i = 0; i < 3000; i++) begin
            logic        v, f, s;
            logic [5:0]  l;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(33, 63))
                                             : 6'($urandom_range(0, 32));
            f = ($urandom_range(0, 24) == 0);
            s = !(($urandom_range(0, 39) == 0) || (m_mode == M_DONE && $urandom_range(0, 2) == 0));
            step("rnd", v, $urandom, l, f, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
